// File: rtl/neuro_video_pkg.sv
// Shared video definitions: pixel width, default luma weights, control bundle.
// Pure declarations; no logic, no latency, no flow control.
package neuro_video_pkg;

    localparam int PIX_W  = 8;
    localparam int DEF_CR = 77;
    localparam int DEF_CG = 150;
    localparam int DEF_CB = 29;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } video_ctrl_t;

endpackage

// File: rtl/ctrl_delay.sv
// N-stage shift register for the de/hs/vs control bundle.
// Latency N cycles; no backpressure, advances every clock.
module ctrl_delay
    import neuro_video_pkg::*;
#(
    parameter int N = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  video_ctrl_t in_ctrl,
    output video_ctrl_t out_ctrl
);

    video_ctrl_t [N-1:0] stage_q;
    video_ctrl_t [N-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = in_ctrl;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_ctrl = stage_q[N-1];

endmodule

// File: rtl/luma_lut_feeder.sv
// RGB->luma feeder for the pixel-mapping LUT; re-aligns de/hs/vs to the LUT result.
// Latency 3 + LUT_LATENCY cycles; no backpressure. Optional stats via LUMA_STATS_EN.
module luma_lut_feeder
    import neuro_video_pkg::*;
#(
    parameter int LUT_LATENCY = 1,
    parameter int CR          = DEF_CR,
    parameter int CG          = DEF_CG,
    parameter int CB          = DEF_CB
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] in_r,
    input  logic [PIX_W-1:0] in_g,
    input  logic [PIX_W-1:0] in_b,
    input  logic             in_de,
    input  logic             in_hs,
    input  logic             in_vs,
    output logic [PIX_W-1:0] lut_a,
    input  logic [PIX_W-1:0] lut_q,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_de,
    output logic             out_hs,
    output logic             out_vs
`ifdef LUMA_STATS_EN
    ,
    output logic [7:0]       stat_min,
    output logic [7:0]       stat_max,
    output logic [15:0]      stat_frames,
    output logic             stat_valid
`endif
);

    video_ctrl_t      in_ctrl;
    video_ctrl_t      s1_ctrl_q, s1_ctrl_d;
    video_ctrl_t      s2_ctrl_q, s2_ctrl_d;
    video_ctrl_t      lut_ctrl;
    video_ctrl_t      out_ctrl;
    logic [15:0]      p_r_q, p_r_d;
    logic [15:0]      p_g_q, p_g_d;
    logic [15:0]      p_b_q, p_b_d;
    logic [17:0]      sum;
    logic [17:0]      sum_sh;
    logic [PIX_W-1:0] lut_a_q, lut_a_d;
    logic [PIX_W-1:0] out_pix_q, out_pix_d;

    always_comb begin
        in_ctrl   = '{de: in_de, hs: in_hs, vs: in_vs};
        s1_ctrl_d = in_ctrl;
        p_r_d     = {8'd0, in_r} * 16'(CR);
        p_g_d     = {8'd0, in_g} * 16'(CG);
        p_b_d     = {8'd0, in_b} * 16'(CB);

        // Round to nearest; anything past 8 bits after the shift saturates.
        sum       = {2'b00, p_r_q} + {2'b00, p_g_q} + {2'b00, p_b_q} + 18'd128;
        sum_sh    = sum >> 8;
        s2_ctrl_d = s1_ctrl_q;
        lut_a_d   = '0;
        if (s1_ctrl_q.de) begin
            lut_a_d = (sum_sh > 18'd255) ? 8'hFF : sum_sh[7:0];
        end

        out_pix_d = lut_ctrl.de ? lut_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ctrl_q <= '0;
            s2_ctrl_q <= '0;
            p_r_q     <= '0;
            p_g_q     <= '0;
            p_b_q     <= '0;
            lut_a_q   <= '0;
            out_pix_q <= '0;
        end else begin
            s1_ctrl_q <= s1_ctrl_d;
            s2_ctrl_q <= s2_ctrl_d;
            p_r_q     <= p_r_d;
            p_g_q     <= p_g_d;
            p_b_q     <= p_b_d;
            lut_a_q   <= lut_a_d;
            out_pix_q <= out_pix_d;
        end
    end

    // Controls track the LUT's read latency, then get one more stage to match out_pix.
    ctrl_delay #(.N(LUT_LATENCY)) u_lut_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_ctrl  (s2_ctrl_q),
        .out_ctrl (lut_ctrl)
    );

    ctrl_delay #(.N(1)) u_out_align (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_ctrl  (lut_ctrl),
        .out_ctrl (out_ctrl)
    );

    assign lut_a   = lut_a_q;
    assign out_pix = out_pix_q;
    assign out_de  = out_ctrl.de;
    assign out_hs  = out_ctrl.hs;
    assign out_vs  = out_ctrl.vs;

`ifdef LUMA_STATS_EN
    logic [7:0]  trk_min_q, trk_min_d;
    logic [7:0]  trk_max_q, trk_max_d;
    logic [7:0]  cur_min, cur_max;
    logic [7:0]  stat_min_q, stat_min_d;
    logic [7:0]  stat_max_q, stat_max_d;
    logic [15:0] stat_frames_q, stat_frames_d;
    logic        stat_valid_q, stat_valid_d;
    logic        vs_prev_q, vs_prev_d;

    always_comb begin
        cur_min = trk_min_q;
        cur_max = trk_max_q;
        if (s2_ctrl_q.de) begin
            if (lut_a_q < cur_min) cur_min = lut_a_q;
            if (lut_a_q > cur_max) cur_max = lut_a_q;
        end

        trk_min_d     = cur_min;
        trk_max_d     = cur_max;
        stat_min_d    = stat_min_q;
        stat_max_d    = stat_max_q;
        stat_frames_d = stat_frames_q;
        stat_valid_d  = 1'b0;
        vs_prev_d     = s2_ctrl_q.vs;

        // Frame boundary: publish, then restart so an empty frame reports 255/0.
        if (s2_ctrl_q.vs && !vs_prev_q) begin
            stat_min_d    = cur_min;
            stat_max_d    = cur_max;
            stat_valid_d  = 1'b1;
            stat_frames_d = stat_frames_q + 16'd1;
            trk_min_d     = 8'hFF;
            trk_max_d     = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_min_q     <= 8'hFF;
            trk_max_q     <= 8'h00;
            stat_min_q    <= '0;
            stat_max_q    <= '0;
            stat_frames_q <= '0;
            stat_valid_q  <= 1'b0;
            vs_prev_q     <= 1'b0;
        end else begin
            trk_min_q     <= trk_min_d;
            trk_max_q     <= trk_max_d;
            stat_min_q    <= stat_min_d;
            stat_max_q    <= stat_max_d;
            stat_frames_q <= stat_frames_d;
            stat_valid_q  <= stat_valid_d;
            vs_prev_q     <= vs_prev_d;
        end
    end

    assign stat_min    = stat_min_q;
    assign stat_max    = stat_max_q;
    assign stat_frames = stat_frames_q;
    assign stat_valid  = stat_valid_q;
`endif

endmodule
